// File: rtl/evo_scheduler.sv
// Generation sequencer and cell-RAM write arbiter for the Game-of-life core.
// Optional EVOLVE watchdog (adds port wdog_err) is enabled by defining EVO_WATCHDOG_EN.
module evo_scheduler #(
    parameter int P_PARAM_M = 5,
    parameter int P_PARAM_N = 5,
    parameter int WIDTH     = 12,
    parameter int TICK_BASE = 1000000,
    parameter int SPEED_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_run,
    input  logic               cmd_pause,
    input  logic               cmd_step,
    input  logic               cmd_clear,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               evo_wden,
    input  logic [2*WIDTH-1:0] evo_wpos,
    input  logic               evo_live,
    input  logic               edit_req,
    input  logic [2*WIDTH-1:0] edit_pos,
    input  logic               edit_val,
    output logic               edit_gnt,
    output logic               global_evo_en,
    output logic               eng_start,
    output logic               ram_we,
    output logic [2*WIDTH-1:0] ram_waddr,
    output logic               ram_wdata,
    output logic [31:0]        gen_count,
    output logic               busy
`ifdef EVO_WATCHDOG_EN
    ,
    output logic               wdog_err
`endif
);

    localparam int              CELLS   = P_PARAM_M * P_PARAM_N;
    localparam int              AW      = 2 * WIDTH;
    localparam logic [AW-1:0]   LP_LAST = AW'(CELLS - 1);

    typedef enum logic [1:0] {S_PAUSED, S_RUN_WAIT, S_EVOLVE, S_CLEAR} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_run_mode, w_run_nxt;
    logic [31:0]   r_cnt;
    logic [31:0]   r_gen_count;
    logic          r_evo_en;
    logic [AW-1:0] r_clr_addr;

    logic [31:0]   w_period;
    logic          w_done, w_toggle, w_gen_inc, w_gen_clr, w_cnt_inc, w_sweep_rst;
    logic          w_wdog_trip;

    assign w_period = 32'(TICK_BASE) * (32'(speed_sel) + 32'd1);
    assign w_done   = evo_wden && (evo_wpos == LP_LAST);

`ifdef EVO_WATCHDOG_EN
    localparam logic [31:0] LP_WDOG_LAST = 32'(4 * CELLS * 8 - 1);
    logic [31:0] r_wdog_cnt;
    logic        r_wdog_err;
    logic        w_wdog_hit;

    assign w_wdog_hit = (r_wdog_cnt == LP_WDOG_LAST);
    assign wdog_err   = r_wdog_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= (r_state == S_EVOLVE && w_state_nxt == S_EVOLVE) ? r_wdog_cnt + 32'd1 : '0;
            if (w_sweep_rst)      r_wdog_err <= 1'b0;
            else if (w_wdog_trip) r_wdog_err <= 1'b1;
        end
    end
`else
    logic w_wdog_hit;
    assign w_wdog_hit = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_mode;
        w_toggle    = 1'b0;
        w_gen_inc   = 1'b0;
        w_gen_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_sweep_rst = 1'b0;
        w_wdog_trip = 1'b0;
        if (cmd_clear) begin
            w_state_nxt = S_CLEAR;
            w_run_nxt   = 1'b0;
            w_sweep_rst = 1'b1;
        end else begin
            case (r_state)
                S_PAUSED: begin
                    if (cmd_run) begin
                        w_run_nxt   = 1'b1;
                        w_state_nxt = S_RUN_WAIT;
                    end else if (cmd_step) begin
                        w_toggle    = 1'b1;
                        w_state_nxt = S_EVOLVE;
                    end
                end
                S_RUN_WAIT: begin
                    if (cmd_pause) begin
                        w_run_nxt   = 1'b0;
                        w_state_nxt = S_PAUSED;
                    end else if (r_cnt >= w_period - 32'd1) begin
                        // Also catches a counter already past a newly shortened period.
                        w_toggle    = 1'b1;
                        w_state_nxt = S_EVOLVE;
                    end else begin
                        w_cnt_inc   = 1'b1;
                    end
                end
                S_EVOLVE: begin
                    if (cmd_pause) w_run_nxt = 1'b0;
                    if (w_done) begin
                        w_gen_inc   = 1'b1;
                        w_state_nxt = (r_run_mode && !cmd_pause) ? S_RUN_WAIT : S_PAUSED;
                    end else if (w_wdog_hit) begin
                        w_wdog_trip = 1'b1;
                        w_run_nxt   = 1'b0;
                        w_state_nxt = S_PAUSED;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_addr == LP_LAST) begin
                        w_gen_clr   = 1'b1;
                        w_state_nxt = S_PAUSED;
                    end
                end
                default: w_state_nxt = S_PAUSED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PAUSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_mode  <= 1'b0;
            r_cnt       <= '0;
            r_gen_count <= '0;
            r_evo_en    <= 1'b0;
            r_clr_addr  <= '0;
        end else begin
            r_run_mode <= w_run_nxt;
            r_cnt      <= w_cnt_inc ? r_cnt + 32'd1 : '0;
            if (w_toggle) r_evo_en <= ~r_evo_en;
            if (w_gen_clr)      r_gen_count <= '0;
            else if (w_gen_inc) r_gen_count <= r_gen_count + 32'd1;
            r_clr_addr <= (w_sweep_rst || r_state != S_CLEAR) ? '0 : r_clr_addr + AW'(1);
        end
    end

    // Single RAM write port: clear sweep beats engine, engine beats editor.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = 1'b0;
        edit_gnt  = 1'b0;
        if (r_state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = r_clr_addr;
        end else if (evo_wden) begin
            ram_we    = 1'b1;
            ram_waddr = evo_wpos;
            ram_wdata = evo_live;
        end else if (edit_req && (r_state == S_PAUSED || r_state == S_RUN_WAIT)) begin
            ram_we    = 1'b1;
            ram_waddr = edit_pos;
            ram_wdata = edit_val;
            edit_gnt  = 1'b1;
        end
    end

    assign global_evo_en = r_evo_en;
    assign gen_count     = r_gen_count;
    assign eng_start     = (r_state == S_CLEAR);
    assign busy          = (r_state == S_EVOLVE) || (r_state == S_CLEAR);

endmodule

// File: tb/tb_evo_scheduler.sv
// Self-checking bench for evo_scheduler: RAM writes are scoreboarded, sequencing is
// checked against bench-side expectations (TICK_BASE=4, 5x5 board).
module tb_evo_scheduler;

    localparam int AW    = 24;
    localparam int CELLS = 25;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
        logic          eng;
        logic          gnt;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_run, cmd_pause, cmd_step, cmd_clear;
    logic [2:0]    speed_sel;
    logic          evo_wden, evo_live, edit_req, edit_val;
    logic [AW-1:0] evo_wpos, edit_pos;
    logic          edit_gnt, global_evo_en, eng_start, ram_we, ram_wdata, busy;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   gen_count;
`ifdef EVO_WATCHDOG_EN
    logic          wdog_err;
`endif

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t wq[$];
    logic exp_en;
    int  n;

    evo_scheduler #(
        .P_PARAM_M(5), .P_PARAM_N(5), .WIDTH(12), .TICK_BASE(4), .SPEED_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .cmd_clear(cmd_clear),
        .speed_sel(speed_sel),
        .evo_wden(evo_wden), .evo_wpos(evo_wpos), .evo_live(evo_live),
        .edit_req(edit_req), .edit_pos(edit_pos), .edit_val(edit_val), .edit_gnt(edit_gnt),
        .global_evo_en(global_evo_en), .eng_start(eng_start),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .gen_count(gen_count), .busy(busy)
`ifdef EVO_WATCHDOG_EN
        , .wdog_err(wdog_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic d, input logic e, input logic g);
        wr_t w;
        w.addr = a; w.data = d; w.eng = e; w.gnt = g;
        wq.push_back(w);
    endtask

    // Every RAM write the DUT performs must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            if (wq.size() == 0) begin
                check("ram_we_unexpected", 1, 0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("ram_waddr", ram_waddr, e.addr);
                check("ram_wdata", ram_wdata, e.data);
                check("eng_start", eng_start, e.eng);
                check("edit_gnt", edit_gnt, e.gnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        cmd_run = 0; cmd_pause = 0; cmd_step = 0; cmd_clear = 0; speed_sel = '0;
        evo_wden = 0; evo_wpos = '0; evo_live = 0;
        edit_req = 0; edit_pos = '0; edit_val = 0;
        exp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_evo_en", global_evo_en, 0);
        check("rst_gen", gen_count, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_ram_we", ram_we, 0);
        rst_n = 1'b1;
        tick();

        // Single step with an editor request stalled across EVOLVE.
        cmd_step = 1; tick(); cmd_step = 0; exp_en = ~exp_en;
        check("step_toggle", global_evo_en, exp_en);
        check("step_busy", busy, 1);
        edit_req = 1; edit_pos = 24'h000102; edit_val = 1;
        cmd_run = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); cmd_run = 0;
            check("stall_gnt", edit_gnt, 0);
        end
        evo_wden = 1; evo_wpos = AW'(CELLS - 1); evo_live = 1;
        push(AW'(CELLS - 1), 1'b1, 1'b0, 1'b0);
        tick(); evo_wden = 0;
        push(24'h000102, 1'b1, 1'b0, 1'b1);
        check("step_gen", gen_count, 1);
        check("step_paused", busy, 0);
        tick(); edit_req = 0;
        repeat (10) tick();
        check("step_single_toggle", global_evo_en, exp_en);
        check("step_stay_paused", busy, 0);

        // Free run at period 8; pause arrives mid-EVOLVE on the third generation.
        speed_sel = 3'd1;
        cmd_run = 1; tick(); cmd_run = 0;
        check("run_wait_busy", busy, 0);
        for (int g = 0; g < 3; g++) begin
            exp_en = ~exp_en;
            n = 0;
            do begin tick(); n++; end while (global_evo_en !== exp_en && n < 20);
            check("run_period", n, 8);
            check("run_evolve_busy", busy, 1);
            evo_wden = 1; evo_wpos = 24'd3; evo_live = 0; cmd_pause = (g == 2);
            push(24'd3, 1'b0, 1'b0, 1'b0);
            tick(); cmd_pause = 0;
            evo_wpos = AW'(CELLS - 1); evo_live = 1;
            push(AW'(CELLS - 1), 1'b1, 1'b0, 1'b0);
            tick(); evo_wden = 0;
            check("run_gen", gen_count, 32'(g + 2));
        end
        repeat (20) tick();
        check("pause_no_toggle", global_evo_en, exp_en);
        check("pause_idle", busy, 0);

        // Clear while running, restarted mid-sweep.
        cmd_run = 1; tick(); cmd_run = 0;
        repeat (3) tick();
        cmd_clear = 1;
        for (int i = 0; i < 5; i++) push(AW'(i), 1'b0, 1'b1, 1'b0);
        tick(); cmd_clear = 0;
        check("clr_eng_start", eng_start, 1);
        check("clr_busy", busy, 1);
        repeat (4) tick();
        cmd_clear = 1;
        for (int i = 0; i < CELLS; i++) push(AW'(i), 1'b0, 1'b1, 1'b0);
        tick(); cmd_clear = 0;
        n = 0;
        while (eng_start && n < 40) begin tick(); n++; end
        check("clr_len", n, CELLS);
        check("clr_gen", gen_count, 0);
        check("clr_done_idle", busy, 0);
        check("clr_queue_empty", wq.size(), 0);
        repeat (20) tick();
        check("clr_run_mode_off", global_evo_en, exp_en);

        // Async reset in the middle of EVOLVE.
        cmd_step = 1; tick(); cmd_step = 0; exp_en = ~exp_en;
        evo_wden = 1; evo_wpos = AW'(CELLS - 1); evo_live = 0;
        push(AW'(CELLS - 1), 1'b0, 1'b0, 1'b0);
        tick(); evo_wden = 0;
        check("pre_rst_gen", gen_count, 1);
        cmd_step = 1; tick(); cmd_step = 0;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0; #1;
        check("mid_rst_evo_en", global_evo_en, 0);
        check("mid_rst_gen", gen_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_eng_start", eng_start, 0);
        exp_en = 1'b0;
        tick(); rst_n = 1'b1; tick();

        // Engine write beats a same-cycle editor request; editor gets the next cycle.
        edit_req = 1; edit_pos = 24'h000203; edit_val = 0;
        evo_wden = 1; evo_wpos = 24'd7; evo_live = 1;
        push(24'd7, 1'b1, 1'b0, 1'b0);
        #1 check("prio_engine_gnt", edit_gnt, 0);
        tick(); evo_wden = 0;
        push(24'h000203, 1'b0, 1'b0, 1'b1);
        #1 check("prio_editor_gnt", edit_gnt, 1);
        tick(); edit_req = 0;
        tick();
        check("prio_gen", gen_count, 0);

`ifdef EVO_WATCHDOG_EN
        cmd_step = 1; tick(); cmd_step = 0;
        n = 0;
        while (!wdog_err && n < 900) begin tick(); n++; end
        check("wdog_cycles", n, 4 * CELLS * 8);
        check("wdog_paused", busy, 0);
`endif

        check("final_queue_empty", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
